rv_decode_stage: RTL and testbench

Parametrised, buffered successor to the combinational RV32 control unit.
- Accepts raw instruction words over a valid/ready handshake.
- Fully decodes each word: control bundle, 4-bit ALU control, sign-extended immediate, illegal flag.
- Queues decoded entries in a DEPTH-entry FIFO between fetch and execute, absorbing execute back-pressure.
- Flushable on branch redirect.

---
 rtl/rv_decode_stage.sv | 273 +++++++++++++++++++++++++++
 tb/tb_rv_decode_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rv_decode_stage.sv
// Buffered RV32/RV64 decode stage: decodes incoming words and queues them in a
// DEPTH-entry FIFO toward execute. Optional M-extension decode: DECODE_M_EXT_EN.
module rv_decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [XLEN-1:0]          out_imm,
  output logic                     out_reg_write,
  output logic                     out_mem_read,
  output logic                     out_mem_write,
  output logic                     out_branch,
  output logic                     out_jump,
  output logic                     out_alu_src,
  output logic                     out_mem_to_reg,
  output logic [2:0]               out_funct3,
  output logic [3:0]               out_alu_ctrl,
  output logic                     out_illegal,
  output logic                     out_muldiv,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            alu_src;
    logic            mem_to_reg;
    logic [2:0]      funct3;
    logic [3:0]      alu_ctrl;
    logic            illegal;
`ifdef DECODE_M_EXT_EN
    logic            muldiv;
`endif
  } entry_t;

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_SLT;
      3'b011:  alu_of = ALU_SLTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [6:0]      shift_f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            ill;
  entry_t          dec;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  // RV64 shifts borrow instr[25] as shamt[5], so only the upper six bits qualify.
  assign shift_f7 = (XLEN == 64) ? {in_instr[31:26], 1'b0} : in_instr[31:25];

  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                in_instr[30:21], 1'b0}));

  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.rd     = in_instr[11:7];
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.funct3 = f3;
    ill        = 1'b0;
    case (opc)
      OPC_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.imm        = imm_i;
        ill            = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = imm_s;
        ill           = (f3 >= 3'b011);
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        dec.imm    = imm_b;
        case (f3[2:1])
          2'b00:   dec.alu_ctrl = ALU_SUB;
          2'b10:   dec.alu_ctrl = ALU_SLT;
          2'b11:   dec.alu_ctrl = ALU_SLTU;
          default: ill = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = imm_i;
        dec.alu_ctrl  = alu_of(f3, in_instr[30] & (f3 == 3'b101));
        if (f3 == 3'b001 || f3 == 3'b101)
          ill = !(shift_f7 == 7'b0000000 || shift_f7 == 7'b0100000);
      end
      OPC_OP: begin
        if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
          dec.reg_write = 1'b1;
          dec.alu_ctrl  = alu_of(f3, in_instr[30]);
        end else if (f7 == 7'b0000001) begin
`ifdef DECODE_M_EXT_EN
          dec.reg_write = 1'b1;
          dec.muldiv    = 1'b1;
          dec.alu_ctrl  = ALU_ADD;
`else
          ill = 1'b1;
`endif
        end else begin
          ill = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = ALU_PASSB;
        dec.imm       = imm_u;
      end
      OPC_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = imm_u;
      end
      OPC_JAL: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.jump      = 1'b1;
        dec.imm       = imm_j;
      end
      OPC_JALR: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.jump      = 1'b1;
        dec.imm       = imm_i;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec.reg_write  = 1'b0;
      dec.mem_read   = 1'b0;
      dec.mem_write  = 1'b0;
      dec.branch     = 1'b0;
      dec.jump       = 1'b0;
      dec.alu_src    = 1'b0;
      dec.mem_to_reg = 1'b0;
      dec.alu_ctrl   = ALU_ADD;
`ifdef DECODE_M_EXT_EN
      dec.muldiv     = 1'b0;
`endif
    end
    dec.illegal = ill;
  end

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop;
  entry_t          head;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  assign head = out_valid ? mem[rd_ptr] : '0;

  assign out_pc         = head.pc;
  assign out_rd         = head.rd;
  assign out_rs1        = head.rs1;
  assign out_rs2        = head.rs2;
  assign out_imm        = head.imm;
  assign out_reg_write  = head.reg_write;
  assign out_mem_read   = head.mem_read;
  assign out_mem_write  = head.mem_write;
  assign out_branch     = head.branch;
  assign out_jump       = head.jump;
  assign out_alu_src    = head.alu_src;
  assign out_mem_to_reg = head.mem_to_reg;
  assign out_funct3     = head.funct3;
  assign out_alu_ctrl   = head.alu_ctrl;
  assign out_illegal    = head.illegal;
`ifdef DECODE_M_EXT_EN
  assign out_muldiv     = head.muldiv;
`else
  assign out_muldiv     = 1'b0;
`endif

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: decode vector table plus FIFO
// full / back-pressure / flush / reset sequences against a small queue model.
module tb_rv_decode_stage;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int PC_W  = 32;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [4:0] out_rd, out_rs1, out_rs2;
  logic [XLEN-1:0] out_imm;
  logic out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump;
  logic out_alu_src, out_mem_to_reg, out_illegal, out_muldiv;
  logic [2:0] out_funct3;
  logic [3:0] out_alu_ctrl;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  rv_decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_branch(out_branch), .out_jump(out_jump),
    .out_alu_src(out_alu_src), .out_mem_to_reg(out_mem_to_reg),
    .out_funct3(out_funct3), .out_alu_ctrl(out_alu_ctrl),
    .out_illegal(out_illegal), .out_muldiv(out_muldiv), .count(count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [PC_W-1:0] q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock with the given inputs; the queue model tracks what the FIFO must hold.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [PC_W-1:0] p,
                       input logic rdy, input logic fl);
    logic push, pop;
    in_valid = v; in_instr = ins; in_pc = p; out_ready = rdy; flush = fl;
    #1;
    chk("in_ready", in_ready, q.size() != DEPTH);
    push = v && (q.size() != DEPTH) && !fl;
    pop  = (q.size() != 0) && rdy && !fl;
    @(posedge clk); #1;
    if (fl || !rst_n) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(p);
    end
    chk("count", count, q.size());
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) chk("out_pc", out_pc, q[0]);
    else begin
      chk("empty_pc", out_pc, 0);
      chk("empty_imm", out_imm, 0);
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic [PC_W-1:0] p);
    mk = {p[11:0], 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  task automatic seq(input logic v, input logic [PC_W-1:0] p, input logic rdy, input logic fl);
    cycle(v, mk(p), p, rdy, fl);
    if (q.size() != 0) chk("seq_imm", out_imm, {20'b0, q[0][11:0]});
  endtask

  // ctrl = {reg_write, mem_read, mem_write, branch, jump, alu_src, mem_to_reg, illegal, muldiv}
  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [8:0]  ctrl;
    logic [3:0]  alu;
  } vec_t;

  vec_t vt[$];

  initial begin
    vt.push_back('{32'h00500093,  5'd1, 32'h00000005, 3'd0, 9'b100001000, 4'd0});  // addi
    vt.push_back('{32'h402081B3,  5'd3, 32'h00000000, 3'd0, 9'b100000000, 4'd1});  // sub
    vt.push_back('{32'h00812283,  5'd5, 32'h00000008, 3'd2, 9'b110001100, 4'd0});  // lw
    vt.push_back('{32'h00512423,  5'd8, 32'h00000008, 3'd2, 9'b001001000, 4'd0});  // sw
    vt.push_back('{32'hFE208EE3, 5'd29, 32'hFFFFFFFC, 3'd0, 9'b000100000, 4'd1});  // beq -4
    vt.push_back('{32'h0020C463,  5'd8, 32'h00000008, 3'd4, 9'b000100000, 4'd3});  // blt +8
    vt.push_back('{32'h123450B7,  5'd1, 32'h12345000, 3'd5, 9'b100001000, 4'd10}); // lui
    vt.push_back('{32'hFFFFF097,  5'd1, 32'hFFFFF000, 3'd7, 9'b100001000, 4'd0});  // auipc
    vt.push_back('{32'h008000EF,  5'd1, 32'h00000008, 3'd0, 9'b100011000, 4'd0});  // jal +8
    vt.push_back('{32'h000080E7,  5'd1, 32'h00000000, 3'd0, 9'b100011000, 4'd0});  // jalr
    vt.push_back('{32'h4020D093,  5'd1, 32'h00000402, 3'd5, 9'b100001000, 4'd7});  // srai
    vt.push_back('{32'h0020B1B3,  5'd3, 32'h00000000, 3'd3, 9'b100000000, 4'd4});  // sltu
    vt.push_back('{32'hFFFFFFFF, 5'd31, 32'h00000000, 3'd7, 9'b000000010, 4'd0});  // unknown
    vt.push_back('{32'h00003083,  5'd1, 32'h00000000, 3'd3, 9'b000000010, 4'd0});  // ld
    vt.push_back('{32'h0420F1B3,  5'd3, 32'h00000000, 3'd7, 9'b000000010, 4'd0});  // bad funct7
`ifdef DECODE_M_EXT_EN
    vt.push_back('{32'h022081B3,  5'd3, 32'h00000000, 3'd0, 9'b100000001, 4'd0});  // mul
`else
    vt.push_back('{32'h022081B3,  5'd3, 32'h00000000, 3'd0, 9'b000000010, 4'd0});  // mul
`endif

    // Reset with a word offered: reset must win and leave the FIFO empty.
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h40;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_pc", out_pc, 0);
    chk("rst_rd", out_rd, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Decode table: push one word, inspect the head, then pop.
    foreach (vt[i]) begin
      cycle(1'b1, vt[i].instr, 32'h1000 + 4 * i, 1'b1, 1'b0);
      chk($sformatf("v%0d_rd", i), out_rd, vt[i].rd);
      chk($sformatf("v%0d_imm", i), out_imm, vt[i].imm);
      chk($sformatf("v%0d_f3", i), out_funct3, vt[i].f3);
      chk($sformatf("v%0d_alu", i), out_alu_ctrl, vt[i].alu);
      chk($sformatf("v%0d_ctrl", i),
          {out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump,
           out_alu_src, out_mem_to_reg, out_illegal, out_muldiv}, vt[i].ctrl);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end

    // Back-pressure: DEPTH+1 offered words, the last one must be refused.
    for (int i = 0; i <= DEPTH; i++) seq(1'b1, 32'h200 + 4 * i, 1'b0, 1'b0);
    chk("full_in_ready", in_ready, 0);
    chk("full_head", out_pc, 32'h200);
    // Streaming while full: first a pop only, then steady push+pop at DEPTH-1.
    for (int i = 0; i < 4; i++) seq(1'b1, 32'h300 + 4 * i, 1'b1, 1'b0);
    chk("stream_count", count, DEPTH - 1);
    for (int i = 0; i <= DEPTH; i++) seq(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with a concurrent push: nothing from before the flush may surface.
    seq(1'b1, 32'h400, 1'b0, 1'b0);
    seq(1'b1, 32'h404, 1'b0, 1'b0);
    seq(1'b1, 32'h408, 1'b1, 1'b1);
    seq(1'b0, 32'h0, 1'b1, 1'b0);
    seq(1'b1, 32'h40C, 1'b1, 1'b0);
    chk("post_flush_head", out_pc, 32'h40C);
    seq(1'b0, 32'h0, 1'b1, 1'b0);

    // Reset coinciding with flush and a push.
    seq(1'b1, 32'h500, 1'b0, 1'b0);
    seq(1'b1, 32'h504, 1'b0, 1'b0);
    rst_n = 1'b0;
    seq(1'b1, 32'h508, 1'b1, 1'b1);
    rst_n = 1'b1;
    seq(1'b1, 32'h50C, 1'b0, 1'b0);
    chk("post_rst_head", out_pc, 32'h50C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
